// File: rtl/dmem_arbiter_pkg.sv
// dmem_arb_defs: definitions shared by the data-memory arbiter and riscv_core.
//   DEF_ADDR_W / DEF_DATA_W : default byte-address and data widths of the core bus
//   arb_state_t             : arbiter FSM states (IDLE, BUSY, RESP)
package dmem_arb_defs;

   localparam int unsigned DEF_ADDR_W = 32;
   localparam int unsigned DEF_DATA_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } arb_state_t;

endpackage

// File: rtl/dmem_arbiter_rr_picker.sv
// rr_picker: combinational rotate-priority encoder.
// Picks the first asserted request at or above rr_ptr, wrapping modulo N.
//   req    in  N      request vector
//   rr_ptr in  IDX_W  index with highest priority this cycle
//   valid  out 1      at least one request is asserted
//   winner out IDX_W  index of the selected request (0 when !valid)
module rr_picker #(
   parameter int unsigned N     = 4,
   parameter int unsigned IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] rr_ptr,
   output logic             valid,
   output logic [IDX_W-1:0] winner
);

   logic [31:0] idx;

   always_comb begin
      valid  = 1'b0;
      winner = '0;
      idx    = '0;
      for (int unsigned k = 0; k < N; k++) begin
         idx = (32'(rr_ptr) + k) % N;
         if (!valid && req[idx]) begin
            valid  = 1'b1;
            winner = IDX_W'(idx);
         end
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter sharing one single-ported data memory
// among NUM_CORES core MEM stages.
//   clk, rst                  clock, synchronous active-high reset
//   core_req/we/addr/wdata/wstrb  per-core request fields (flattened, core i at slice i)
//   core_ack                  one-hot, one-cycle completion pulse
//   core_rdata                read data broadcast to all cores, valid with core_ack
//   mem_req/we/addr/wdata/wstrb   latched transaction towards the memory
//   mem_rdata, mem_ack        memory response
// All outputs are decoded from state and registers only.
module dmem_arbiter
   import dmem_arb_defs::*;
#(
   parameter int unsigned NUM_CORES = 4,
   parameter int unsigned ADDR_W    = DEF_ADDR_W,
   parameter int unsigned DATA_W    = DEF_DATA_W
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_CORES-1:0]          core_req,
   input  logic [NUM_CORES-1:0]          core_we,
   input  logic [NUM_CORES*ADDR_W-1:0]   core_addr,
   input  logic [NUM_CORES*DATA_W-1:0]   core_wdata,
   input  logic [NUM_CORES*DATA_W/8-1:0] core_wstrb,
   output logic [NUM_CORES-1:0]          core_ack,
   output logic [DATA_W-1:0]             core_rdata,
   output logic                          mem_req,
   output logic                          mem_we,
   output logic [ADDR_W-1:0]             mem_addr,
   output logic [DATA_W-1:0]             mem_wdata,
   output logic [DATA_W/8-1:0]           mem_wstrb,
   input  logic [DATA_W-1:0]             mem_rdata,
   input  logic                          mem_ack
);

   localparam int unsigned IDX_W  = $clog2(NUM_CORES);
   localparam int unsigned STRB_W = DATA_W / 8;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CORES - 1);

   arb_state_t        state, state_next;
   logic [IDX_W-1:0]  rr_ptr;
   logic [IDX_W-1:0]  grant;
   logic [IDX_W-1:0]  pick_idx;
   logic              pick_valid;
   logic [31:0]       sel;

   logic              lat_we;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;
   logic [STRB_W-1:0] lat_wstrb;
   logic [DATA_W-1:0] rdata_q;

   rr_picker #(
      .N     (NUM_CORES),
      .IDX_W (IDX_W)
   ) u_picker (
      .req    (core_req),
      .rr_ptr (rr_ptr),
      .valid  (pick_valid),
      .winner (pick_idx)
   );

   always_comb sel = 32'(pick_idx);

   always_comb begin
      state_next = state;
      unique case (state)
         ST_IDLE: if (pick_valid) state_next = ST_BUSY;
         ST_BUSY: if (mem_ack)    state_next = ST_RESP;
         ST_RESP:                 state_next = ST_IDLE;
         default:                 state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         rr_ptr    <= '0;
         grant     <= '0;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_wstrb <= '0;
         rdata_q   <= '0;
      end else begin
         state <= state_next;
         // Core inputs are only looked at here; later changes cannot disturb
         // the transaction in flight.
         if (state == ST_IDLE && pick_valid) begin
            grant     <= pick_idx;
            rr_ptr    <= (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;
            lat_we    <= core_we[pick_idx];
            lat_addr  <= core_addr[sel*ADDR_W +: ADDR_W];
            lat_wdata <= core_wdata[sel*DATA_W +: DATA_W];
            lat_wstrb <= core_wstrb[sel*STRB_W +: STRB_W];
         end
         if (state == ST_BUSY && mem_ack) begin
            rdata_q <= mem_rdata;
         end
      end
   end

   always_comb begin
      core_ack = '0;
      if (state == ST_RESP) core_ack[grant] = 1'b1;
   end

   assign core_rdata = rdata_q;
   assign mem_req    = (state == ST_BUSY);
   assign mem_we     = lat_we;
   assign mem_addr   = lat_addr;
   assign mem_wdata  = lat_wdata;
   assign mem_wstrb  = lat_wstrb;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios followed by a randomized run checked
// against a transaction-level model of the arbiter (grant order, latencies,
// latched fields, read data).
module tb_dmem_arbiter;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   core_req, core_we;
   logic [127:0] core_addr, core_wdata;
   logic [15:0]  core_wstrb;
   logic [3:0]   core_ack;
   logic [31:0]  core_rdata;
   logic         mem_req, mem_we;
   logic [31:0]  mem_addr, mem_wdata, mem_rdata;
   logic [3:0]   mem_wstrb;
   logic         mem_ack;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   logic        pend   [4];
   logic        f_we   [4];
   logic [31:0] f_addr [4];
   logic [31:0] f_wdata[4];
   logic [3:0]  f_wstrb[4];

   dmem_arbiter #(
      .NUM_CORES (4),
      .ADDR_W    (32),
      .DATA_W    (32)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .core_req   (core_req),
      .core_we    (core_we),
      .core_addr  (core_addr),
      .core_wdata (core_wdata),
      .core_wstrb (core_wstrb),
      .core_ack   (core_ack),
      .core_rdata (core_rdata),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_wstrb  (mem_wstrb),
      .mem_rdata  (mem_rdata),
      .mem_ack    (mem_ack)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_core(input int i, input logic we, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s);
      pend[i] = 1'b1; f_we[i] = we; f_addr[i] = a; f_wdata[i] = d; f_wstrb[i] = s;
   endtask

   task automatic drive();
      for (int i = 0; i < 4; i++) begin
         core_req[i]            = pend[i];
         core_we[i]             = f_we[i];
         core_addr[i*32 +: 32]  = f_addr[i];
         core_wdata[i*32 +: 32] = f_wdata[i];
         core_wstrb[i*4 +: 4]   = f_wstrb[i];
      end
   endtask

   task automatic clear_all();
      for (int i = 0; i < 4; i++) begin
         pend[i] = 1'b0; f_we[i] = 1'b0; f_addr[i] = '0; f_wdata[i] = '0; f_wstrb[i] = '0;
      end
   endtask

   // randomized-phase model variables
   int          free_cyc, g, lat, ack_at, win, ptr, last_ack;
   logic        txn, busy_now, any;
   logic        cap_we;
   logic [31:0] cap_addr, cap_wdata, m_rdata;
   logic [3:0]  cap_wstrb;

   initial begin
      rst = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
      clear_all(); drive();
      step(); step();
      rst = 1'b0;

      // reset values
      chk("rst_mem_req",    mem_req,    0);
      chk("rst_mem_we",     mem_we,     0);
      chk("rst_mem_addr",   mem_addr,   0);
      chk("rst_mem_wdata",  mem_wdata,  0);
      chk("rst_mem_wstrb",  mem_wstrb,  0);
      chk("rst_core_ack",   core_ack,   0);
      chk("rst_core_rdata", core_rdata, 0);

      // contention: all four cores store, memory acks in third BUSY cycle
      for (int i = 0; i < 4; i++) set_core(i, 1'b1, 32'h200 + 32'(i) * 4, 32'(i), 4'hF);
      drive();
      last_ack = -1;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("cont_mem_req",   mem_req,   1);
         chk("cont_mem_wdata", mem_wdata, 64'(k % 4));
         chk("cont_mem_we",    mem_we,    1);
         step();
         step();
         mem_ack = 1'b1; mem_rdata = $urandom;
         step();
         mem_ack = 1'b0;
         chk("cont_ack", core_ack, 64'd1 << (k % 4));
         if (k > 0) chk("cont_ack_gap", 64'(cyc - last_ack), 5);
         last_ack = cyc;
         if (k == 4) begin
            clear_all(); drive();
         end
         step();
      end

      // single load from core 2 with zero-wait memory
      set_core(2, 1'b0, 32'h100, 32'h0, 4'h0); drive();
      step();
      chk("load_mem_req",  mem_req,  1);
      chk("load_mem_addr", mem_addr, 32'h100);
      chk("load_mem_we",   mem_we,   0);
      mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
      step();
      mem_ack = 1'b0;
      chk("load_mem_req_drop", mem_req,    0);
      chk("load_ack",          core_ack,   4'b0100);
      chk("load_rdata",        core_rdata, 32'hDEADBEEF);
      pend[2] = 1'b0; drive();
      step();
      chk("load_ack_once", core_ack, 0);
      chk("load_idle_req", mem_req,  0);

      // pointer wrap: rr_ptr is 3, cores 0 and 1 request
      set_core(1, 1'b0, 32'h14, 32'h0, 4'h0);
      set_core(0, 1'b0, 32'h10, 32'h0, 4'h0);
      drive();
      step();
      chk("wrap_first_addr", mem_addr, 32'h10);
      mem_ack = 1'b1; mem_rdata = 32'h11111111;
      step();
      mem_ack = 1'b0;
      chk("wrap_first_ack", core_ack, 4'b0001);
      pend[0] = 1'b0; drive();
      step();
      chk("wrap_idle_gap", mem_req, 0);
      step();
      chk("wrap_second_req",  mem_req,  1);
      chk("wrap_second_addr", mem_addr, 32'h14);
      mem_ack = 1'b1; mem_rdata = 32'h22222222;
      step();
      mem_ack = 1'b0;
      chk("wrap_second_ack", core_ack, 4'b0010);
      pend[1] = 1'b0; drive();
      step();

      // stable latch: address changes illegally during BUSY
      set_core(1, 1'b0, 32'h40, 32'h0, 4'h0); drive();
      step();
      chk("stable_addr_b1", mem_addr, 32'h40);
      f_addr[1] = 32'h80; drive();
      step();
      chk("stable_addr_b2", mem_addr, 32'h40);
      chk("stable_req_b2",  mem_req,  1);
      mem_ack = 1'b1; mem_rdata = 32'h5555AAAA;
      step();
      mem_ack = 1'b0;
      chk("stable_ack",       core_ack, 4'b0010);
      chk("stable_addr_resp", mem_addr, 32'h40);
      pend[1] = 1'b0; drive();
      step();
      chk("stable_ack_once", core_ack, 0);
      step();
      chk("stable_ack_none", core_ack, 0);
      chk("stable_idle",     mem_req,  0);

      // stray acks in IDLE and RESP
      mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
      step();
      mem_ack = 1'b0;
      chk("stray_idle_req",   mem_req,    0);
      chk("stray_idle_ack",   core_ack,   0);
      chk("stray_idle_rdata", core_rdata, 32'h5555AAAA);
      set_core(3, 1'b1, 32'h300, 32'hCAFE0003, 4'h3); drive();
      step();
      chk("stray_busy_req", mem_req, 1);
      mem_ack = 1'b1; mem_rdata = 32'h33333333;
      step();
      chk("stray_resp_ack", core_ack, 4'b1000);
      pend[3] = 1'b0; drive();
      mem_rdata = 32'hBAD1BAD1;   // mem_ack still high: stray in RESP
      step();
      mem_ack = 1'b0;
      chk("stray_resp_noack", core_ack,   0);
      chk("stray_resp_noreq", mem_req,    0);
      chk("stray_resp_rdata", core_rdata, 32'h33333333);
      step();
      chk("stray_after_ack", core_ack, 0);
      chk("stray_after_req", mem_req,  0);

      // reset in BUSY with simultaneous mem_ack
      set_core(0, 1'b1, 32'h500, 32'h12345678, 4'hF); drive();
      step();
      chk("rmid_busy", mem_req, 1);
      rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h77777777;
      step();
      rst = 1'b0; mem_ack = 1'b0;
      pend[0] = 1'b0; drive();
      chk("rmid_mem_req",  mem_req,    0);
      chk("rmid_core_ack", core_ack,   0);
      chk("rmid_mem_addr", mem_addr,   0);
      chk("rmid_rdata",    core_rdata, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rmid_no_ack", core_ack, 0);
         chk("rmid_no_req", mem_req,  0);
      end
      // rr_ptr back at 0: core 0 wins over core 1
      set_core(1, 1'b0, 32'h61, 32'h0, 4'h0);
      set_core(0, 1'b0, 32'h60, 32'h0, 4'h0);
      drive();
      step();
      chk("rmid_ptr_addr", mem_addr, 32'h60);
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      chk("rmid_ptr_ack0", core_ack, 4'b0001);
      pend[0] = 1'b0; drive();
      step();
      step();
      chk("rmid_ptr_addr1", mem_addr, 32'h61);
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      chk("rmid_ptr_ack1", core_ack, 4'b0010);
      pend[1] = 1'b0; drive();
      step();

      // randomized run against a transaction-level model
      rst = 1'b1; clear_all(); drive();
      step();
      rst = 1'b0;
      free_cyc = cyc; txn = 1'b0; ptr = 0; ack_at = -1; g = 0; lat = 0; win = 0;
      cap_we = 1'b0; cap_addr = '0; cap_wdata = '0; cap_wstrb = '0; m_rdata = '0;
      for (int n = 0; n < 1500; n++) begin
         busy_now = txn && (cyc > g) && (cyc <= g + 1 + lat);
         chk("rnd_mem_req", mem_req, 64'(busy_now));
         if (busy_now) begin
            chk("rnd_mem_we",    mem_we,    64'(cap_we));
            chk("rnd_mem_addr",  mem_addr,  cap_addr);
            chk("rnd_mem_wdata", mem_wdata, cap_wdata);
            chk("rnd_mem_wstrb", mem_wstrb, cap_wstrb);
         end
         if (txn && cyc == ack_at) begin
            chk("rnd_ack",   core_ack,   64'd1 << win);
            chk("rnd_rdata", core_rdata, m_rdata);
            // acked core either drops or issues a fresh request
            pend[win] = 1'b0;
            if ($urandom_range(1, 0) == 1)
               set_core(win, 1'($urandom), $urandom, $urandom, 4'($urandom));
         end else begin
            chk("rnd_no_ack", core_ack, 0);
         end
         for (int i = 0; i < 4; i++) begin
            if (!pend[i] && !(txn && i == win && cyc < ack_at) && $urandom_range(3, 0) == 0)
               set_core(i, 1'($urandom), $urandom, $urandom, 4'($urandom));
         end
         // illegal disturbance of the granted core while memory is busy
         if (busy_now && $urandom_range(2, 0) == 0) f_addr[win] = $urandom;
         if (busy_now && $urandom_range(7, 0) == 0) pend[win] = 1'b0;
         if (cyc == free_cyc) begin
            any = 1'b0;
            for (int k = 0; k < 4; k++) begin
               if (!any && pend[(ptr + k) % 4]) begin
                  any = 1'b1;
                  win = (ptr + k) % 4;
               end
            end
            if (any) begin
               cap_we = f_we[win]; cap_addr = f_addr[win];
               cap_wdata = f_wdata[win]; cap_wstrb = f_wstrb[win];
               ptr = (win + 1) % 4;
               g = cyc; lat = $urandom_range(3, 0);
               ack_at = cyc + 2 + lat; free_cyc = cyc + 3 + lat;
               txn = 1'b1;
            end else begin
               free_cyc = cyc + 1;
            end
         end
         mem_rdata = $urandom;
         if (txn && cyc == g + 1 + lat) begin
            mem_ack = 1'b1; m_rdata = mem_rdata;
         end else if (txn && cyc > g && cyc <= g + 1 + lat) begin
            mem_ack = 1'b0;
         end else begin
            mem_ack = ($urandom_range(5, 0) == 0);
         end
         drive();
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
